// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
//
// N-master Wishbone B3 arbiter. Several masters share one slave. The arbiter
// grants the bus round-robin and locks it at cycle level: once a master owns
// the bus, it keeps it for as long as its wbm_cyc_i stays high. This covers
// multi-beat bursts and gaps in stb.
//
// Optional feature (compile-time macro WB_RR_ARB_WATCHDOG_EN):
//   This is a stalled-slave watchdog. Suppose the owner holds stb for
//   `timeout` cycles and the slave gives no response. Then the arbiter
//   answers err to the owner for one cycle, and it masks stb to the slave in
//   that same cycle. The owner keeps the bus. When the macro is undefined,
//   `timeout` is only range-checked.
//
// Parameters:
//   num_masters  number of master ports (2..16)
//   aw, dw       address / data width; the select width is dw/8
//   timeout      watchdog limit in cycles (1..65535)
//
// Ports:
//   wb_clk_i, wb_rst_i           clock, synchronous active-high reset
//   wbm_*_i                      packed master request buses; master m uses
//                                slice [m*W +: W]
//   wbm_dat_o                    slave read data, broadcast to every master
//   wbm_ack_o/err_o/rty_o        per-master termination; only the owner
//                                sees non-zero values
//   wbs_*_o                      slave-side request, the owner's slice or
//                                all zero when idle
//   wbs_dat_i/ack_i/err_i/rty_i  slave response
//   grant_o                      one-hot current owner; zero when idle
// ---------------------------------------------------------------------------
module wb_rr_arbiter #(
  parameter int num_masters = 3,
  parameter int aw          = 32,
  parameter int dw          = 32,
  parameter int timeout     = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  // master side
  input  logic [num_masters*aw-1:0]   wbm_adr_i,
  input  logic [num_masters*dw-1:0]   wbm_dat_i,
  input  logic [num_masters*dw/8-1:0] wbm_sel_i,
  input  logic [num_masters-1:0]      wbm_we_i,
  input  logic [num_masters-1:0]      wbm_cyc_i,
  input  logic [num_masters-1:0]      wbm_stb_i,
  input  logic [num_masters*3-1:0]    wbm_cti_i,
  input  logic [num_masters*2-1:0]    wbm_bte_i,
  output logic [num_masters*dw-1:0]   wbm_dat_o,
  output logic [num_masters-1:0]      wbm_ack_o,
  output logic [num_masters-1:0]      wbm_err_o,
  output logic [num_masters-1:0]      wbm_rty_o,
  // slave side
  output logic [aw-1:0]               wbs_adr_o,
  output logic [dw-1:0]               wbs_dat_o,
  output logic [dw/8-1:0]             wbs_sel_o,
  output logic                        wbs_we_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  input  logic [dw-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i,
  // status
  output logic [num_masters-1:0]      grant_o
);

  localparam int sw    = dw / 8;
  localparam int idx_w = $clog2(num_masters);

  typedef logic [idx_w-1:0] idx_t;
  typedef enum logic {IDLE, OWNED} state_t;

  // Elaboration-time parameter range checks.
  if (num_masters < 2 || num_masters > 16) begin : g_bad_num_masters
    $error("wb_rr_arbiter: num_masters must be in 2..16");
  end
  if (timeout < 1 || timeout > 65535) begin : g_bad_timeout
    $error("wb_rr_arbiter: timeout must be in 1..65535");
  end

  state_t state;
  idx_t   owner;     // current owner; meaningful only in OWNED
  idx_t   last;      // most recent owner; round-robin scan starts after it
  logic   owned;
  logic   arb_en;
  logic   rr_found;
  idx_t   rr_winner;
  idx_t   rr_cand;
  logic   wd_fire;

  assign owned = (state == OWNED);

  // Arbitrate when the bus is free, or when the owner has released cyc.
  // Because of the release case, handover costs no extra cycle.
  assign arb_en = !owned || !wbm_cyc_i[owner];

  // Round-robin scan: last+1, last+2, ..., wrapping. The scan ends at `last`
  // itself, so a lone requester can win the bus back.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment. If a path leaves a variable unassigned, a latch is inferred.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    rr_cand   = '0;
    for (int i = 1; i <= num_masters; i++) begin
      rr_cand = idx_t'((int'(last) + i) % num_masters);
      if (!rr_found && wbm_cyc_i[rr_cand]) begin
        rr_found  = 1'b1;
        rr_winner = rr_cand;
      end
    end
  end

  // NOTE: clocked state is written with non-blocking assignments only. All
  // registers then update together from values sampled before the edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      owner <= '0;
      last  <= idx_t'(num_masters - 1);   // master 0 wins first
    end else if (arb_en) begin
      if (rr_found) begin
        state <= OWNED;
        owner <= rr_winner;
        last  <= rr_winner;
      end else begin
        state <= IDLE;
      end
    end
  end

`ifdef WB_RR_ARB_WATCHDOG_EN
  localparam int cnt_w = $clog2(timeout + 1);

  logic [cnt_w-1:0] wd_cnt;

  assign wd_fire = owned && (wd_cnt == cnt_w'(timeout));

  // Counts consecutive stalled strobe cycles of the current owner. The count
  // restarts on any response, an stb gap, a handover or a firing.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wd_cnt <= '0;
    end else if (!owned || arb_en || wd_fire || !wbm_stb_i[owner] ||
                 wbs_ack_i || wbs_err_i || wbs_rty_i) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  // Slave-side request mux: the owner's slice, or all zero when idle.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    if (owned) begin
      wbs_adr_o = wbm_adr_i[owner*aw +: aw];
      wbs_dat_o = wbm_dat_i[owner*dw +: dw];
      wbs_sel_o = wbm_sel_i[owner*sw +: sw];
      wbs_we_o  = wbm_we_i[owner];
      wbs_cyc_o = wbm_cyc_i[owner];
      wbs_stb_o = wbm_stb_i[owner] & ~wd_fire;
      wbs_cti_o = wbm_cti_i[owner*3 +: 3];
      wbs_bte_o = wbm_bte_i[owner*2 +: 2];
    end
  end

  // Response routing and grant. Both are combinational, so a slave ack
  // reaches the owner in the same cycle.
  always_comb begin
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    grant_o   = '0;
    if (owned) begin
      wbm_ack_o[owner] = wbs_ack_i;
      wbm_err_o[owner] = wbs_err_i | wd_fire;
      wbm_rty_o[owner] = wbs_rty_i;
      grant_o[owner]   = 1'b1;
    end
  end

  assign wbm_dat_o = {num_masters{wbs_dat_i}};

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_rr_arbiter
//
// Directed bench for wb_rr_arbiter with 5 masters and timeout=8.
// Each stimulus step drives one cycle of inputs. In the same step it pushes
// the hand-computed expected owner-side view of that cycle into a queue.
// A monitor process samples on the falling edge and compares against the
// head of the queue.
// ---------------------------------------------------------------------------
module tb_wb_rr_arbiter;

  localparam int nm = 5;
  localparam int aw = 32;
  localparam int dw = 32;

`ifdef WB_RR_ARB_WATCHDOG_EN
  localparam bit wd_on = 1'b1;
`else
  localparam bit wd_on = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [4:0]  grant;
    logic        cyc;
    logic        stb;
    logic [31:0] adr;
    logic [4:0]  ack;
    logic [4:0]  err;
  } exp_t;

  logic clk;
  logic rst;
  logic [nm-1:0] m_cyc;
  logic [nm-1:0] m_stb;
  logic [2:0]    m0_cti;
  logic          s_ack;
  logic          s_err;

  logic [31:0] adr_tbl [nm] = '{32'h040, 32'h100, 32'h200, 32'h300, 32'h400};

  logic [nm*aw-1:0]   wbm_adr;
  logic [nm*dw-1:0]   wbm_dat;
  logic [nm*dw/8-1:0] wbm_sel;
  logic [nm-1:0]      wbm_we;
  logic [nm*3-1:0]    wbm_cti;
  logic [nm*2-1:0]    wbm_bte;
  logic [nm*dw-1:0]   wbm_dat_o;
  logic [nm-1:0]      wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [aw-1:0]      wbs_adr_o;
  logic [dw-1:0]      wbs_dat_o;
  logic [dw/8-1:0]    wbs_sel_o;
  logic               wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]         wbs_cti_o;
  logic [1:0]         wbs_bte_o;
  logic [nm-1:0]      grant_o;

  assign wbm_adr = {32'h400, 32'h300, 32'h200, 32'h100, 32'h040};
  assign wbm_dat = {32'hD4, 32'hD3, 32'hD2, 32'hD1, 32'hD0};
  assign wbm_sel = '1;
  assign wbm_we  = '0;
  assign wbm_cti = {12'd0, m0_cti};
  assign wbm_bte = '0;

  wb_rr_arbiter #(.num_masters(nm), .aw(aw), .dw(dw), .timeout(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbm_adr_i(wbm_adr),
    .wbm_dat_i(wbm_dat),
    .wbm_sel_i(wbm_sel),
    .wbm_we_i (wbm_we),
    .wbm_cyc_i(m_cyc),
    .wbm_stb_i(m_stb),
    .wbm_cti_i(wbm_cti),
    .wbm_bte_i(wbm_bte),
    .wbm_dat_o(wbm_dat_o),
    .wbm_ack_o(wbm_ack_o),
    .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o),
    .wbs_dat_o(wbs_dat_o),
    .wbs_sel_o(wbs_sel_o),
    .wbs_we_o (wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o),
    .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o),
    .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(32'hCAFE_0000),
    .wbs_ack_i(s_ack),
    .wbs_err_i(s_err),
    .wbs_rty_i(1'b0),
    .grant_o  (grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", what, act, want);
    end
  endtask

  // Monitor: compares the DUT's combinational outputs mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({e.name, ".grant"},   32'(grant_o),   32'(e.grant));
        check({e.name, ".wbs_cyc"}, 32'(wbs_cyc_o), 32'(e.cyc));
        check({e.name, ".wbs_stb"}, 32'(wbs_stb_o), 32'(e.stb));
        check({e.name, ".wbs_adr"}, wbs_adr_o,      e.adr);
        check({e.name, ".ack"},     32'(wbm_ack_o), 32'(e.ack));
        check({e.name, ".err"},     32'(wbm_err_o), 32'(e.err));
      end
    end
  end

  // One cycle of stimulus. `owner` is the hand-computed owner expected
  // during this cycle (-1 means idle). `wd` marks a watchdog firing.
  task automatic step(input string name, input bit r, input logic [4:0] cyc,
                      input bit ack, input bit err, input int owner, input bit wd);
    exp_t e;
    rst   = r;
    m_cyc = cyc;
    m_stb = cyc;
    s_ack = ack;
    s_err = err;
    e.name  = name;
    e.grant = (owner >= 0) ? (5'b00001 << owner) : 5'b0;
    e.cyc   = (owner >= 0) ? cyc[owner] : 1'b0;
    e.stb   = (owner >= 0) ? (cyc[owner] & ~wd) : 1'b0;
    e.adr   = (owner >= 0) ? adr_tbl[owner] : 32'h0;
    e.ack   = (owner >= 0 && ack) ? e.grant : 5'b0;
    e.err   = (owner >= 0 && (err || wd)) ? e.grant : 5'b0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    m_cyc  = '0;
    m_stb  = '0;
    s_ack  = 1'b0;
    s_err  = 1'b0;
    m0_cti = 3'b000;
    @(posedge clk);
    #1;
    step("reset", 1'b1, 5'b00000, 0, 0, -1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1) Grant latency, routing of ack/err to the owner only.
    do_reset();
    step("t1_c0", 0, 5'b00010, 0, 0, -1, 0);
    step("t1_c1", 0, 5'b00010, 0, 0,  1, 0);
    step("t1_c2", 0, 5'b00010, 1, 0,  1, 0);
    step("t1_c3", 0, 5'b00010, 0, 1,  1, 0);
    step("t1_c4", 0, 5'b00000, 0, 0,  1, 0);
    step("t1_c5", 0, 5'b00000, 0, 0, -1, 0);

    // 2) Three masters rotate 0,1,2,0,1,2 with zero-bubble handover.
    do_reset();
    step("t2_c0",  0, 5'b00111, 0, 0, -1, 0);
    step("t2_c1",  0, 5'b00111, 1, 0,  0, 0);
    step("t2_c2",  0, 5'b00110, 0, 0,  0, 0);
    step("t2_c3",  0, 5'b00111, 1, 0,  1, 0);
    step("t2_c4",  0, 5'b00101, 0, 0,  1, 0);
    step("t2_c5",  0, 5'b00111, 1, 0,  2, 0);
    step("t2_c6",  0, 5'b00011, 0, 0,  2, 0);
    step("t2_c7",  0, 5'b00111, 1, 0,  0, 0);
    step("t2_c8",  0, 5'b00110, 0, 0,  0, 0);
    step("t2_c9",  0, 5'b00111, 1, 0,  1, 0);
    step("t2_c10", 0, 5'b00101, 0, 0,  1, 0);
    step("t2_c11", 0, 5'b00111, 1, 0,  2, 0);
    step("t2_c12", 0, 5'b00000, 0, 0,  2, 0);
    step("t2_c13", 0, 5'b00000, 0, 0, -1, 0);

    // 3) Master 0 runs a 4-beat burst; master 2 waits until cyc falls.
    do_reset();
    m0_cti = 3'b010;
    step("t3_c0", 0, 5'b00001, 0, 0, -1, 0);
    step("t3_b1", 0, 5'b00101, 1, 0,  0, 0);
    step("t3_b2", 0, 5'b00101, 1, 0,  0, 0);
    step("t3_b3", 0, 5'b00101, 1, 0,  0, 0);
    m0_cti = 3'b111;
    step("t3_b4", 0, 5'b00101, 1, 0,  0, 0);
    m0_cti = 3'b000;
    step("t3_c5", 0, 5'b00100, 0, 0,  0, 0);
    step("t3_c6", 0, 5'b00100, 1, 0,  2, 0);
    step("t3_c7", 0, 5'b00000, 0, 0,  2, 0);
    step("t3_c8", 0, 5'b00000, 0, 0, -1, 0);

    // 4) last=4 after reset: masters 0 and 3 request together.
    do_reset();
    step("t4_c0", 0, 5'b01001, 0, 0, -1, 0);
    step("t4_c1", 0, 5'b01001, 1, 0,  0, 0);
    step("t4_c2", 0, 5'b01000, 0, 0,  0, 0);
    step("t4_c3", 0, 5'b01000, 1, 0,  3, 0);
    step("t4_c4", 0, 5'b00000, 0, 0,  3, 0);
    step("t4_c5", 0, 5'b00000, 0, 0, -1, 0);

    // 5) Reset during an owned transfer; a late ack is discarded.
    do_reset();
    step("t5_c0", 0, 5'b00100, 0, 0, -1, 0);
    step("t5_c1", 0, 5'b00100, 0, 0,  2, 0);
    step("t5_c2", 1, 5'b00100, 0, 0,  2, 0);
    step("t5_c3", 0, 5'b00101, 1, 0, -1, 0);
    step("t5_c4", 0, 5'b00101, 1, 0,  0, 0);
    step("t5_c5", 0, 5'b00100, 0, 0,  0, 0);
    step("t5_c6", 0, 5'b00100, 1, 0,  2, 0);
    step("t5_c7", 0, 5'b00000, 0, 0,  2, 0);
    step("t5_c8", 0, 5'b00000, 0, 0, -1, 0);

    // 6) Stalled slave: err 8 cycles after stb rises (watchdog build only).
    do_reset();
    step("t6_c0", 0, 5'b00010, 0, 0, -1, 0);
    for (int i = 1; i <= 8; i++)
      step($sformatf("t6_c%0d", i), 0, 5'b00010, 0, 0, 1, 0);
    step("t6_c9",  0, 5'b00010, 0, 0,  1, wd_on);
    step("t6_c10", 0, 5'b00010, 0, 0,  1, 0);
    step("t6_c11", 0, 5'b00000, 0, 0,  1, 0);
    step("t6_c12", 0, 5'b00000, 0, 0, -1, 0);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
